// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  localparam int DUTY_SCALE = 100;
  localparam int DUTY_W     = 7;
  // Cycles after reset before s2 reflects the real pin level.
  localparam int SETTLE_CYCLES = 2;

endpackage

// File: rtl/pwm_div.sv
// Sequential restoring divider, one quotient bit per cycle.
// busy covers the NUM_W iterations plus one drain cycle; done and quotient are valid in the last iteration cycle.
module pwm_div #(
  parameter int NUM_W = 23,
  parameter int DEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DEN_W-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] quotient
);

  localparam int IDX_W = $clog2(NUM_W + 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic [NUM_W-1:0] quo_q, quo_d;
  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [DEN_W:0]   trial;

  always_comb begin
    idx_d  = idx_q;
    busy_d = busy_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    den_d  = den_q;
    done   = 1'b0;
    trial  = {rem_q, quo_q[NUM_W-1]};
    if (!busy_q) begin
      if (start) begin
        busy_d = 1'b1;
        idx_d  = IDX_W'(NUM_W);
        quo_d  = numerator;
        rem_d  = '0;
        den_d  = denominator;
      end
    end else if (idx_q != '0) begin
      if (trial >= {1'b0, den_q}) begin
        rem_d = DEN_W'(trial - {1'b0, den_q});
        quo_d = {quo_q[NUM_W-2:0], 1'b1};
      end else begin
        rem_d = trial[DEN_W-1:0];
        quo_d = {quo_q[NUM_W-2:0], 1'b0};
      end
      idx_d = idx_q - 1'b1;
      done  = (idx_q == IDX_W'(1));
    end else begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      busy_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
    end else begin
      idx_q  <= idx_d;
      busy_q <= busy_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
    end
  end

  assign busy     = busy_q;
  assign quotient = quo_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of a pin waveform and reports integer duty percent.
//   state      | meaning
//   ST_IDLE    | wait for a settled low level on the synchronized pin
//   ST_ARM     | wait for the first rise; no result from it
//   ST_MEASURE | latch high time on fall, report period on every rise
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period_cnt,
  output logic [CNT_W-1:0]  high_cnt,
  output logic [DUTY_W-1:0] duty_pct,
  output logic              valid,
  output logic              overrun,
  output logic              timeout
);

  localparam int              NUM_W   = CNT_W + DUTY_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]        settle_q, settle_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  hi_q, hi_d;
  logic [CNT_W-1:0]  res_per_q, res_per_d;
  logic [CNT_W-1:0]  res_hi_q, res_hi_d;
  logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  logic              rise, fall;
  logic              div_start, div_busy, div_done;
  logic [NUM_W-1:0]  div_num, div_quo;
  logic              unused_quo_hi;

  assign rise          = s2_q & ~s3_q;
  assign fall          = ~s2_q & s3_q;
  assign div_num       = NUM_W'(hi_q) * NUM_W'(DUTY_SCALE);
  assign unused_quo_hi = ^div_quo[NUM_W-1:DUTY_W];

  always_comb begin
    s1_d         = pwm_in;
    s2_d         = s1_q;
    s3_d         = s2_q;
    settle_d     = (settle_q != 2'd0) ? settle_q - 2'd1 : 2'd0;
    cnt_d        = rise ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
    state_d      = state_q;
    hi_d         = hi_q;
    res_per_d    = res_per_q;
    res_hi_d     = res_hi_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    duty_d       = duty_q;
    valid_d      = 1'b0;
    overrun_d    = 1'b0;
    timeout_d    = 1'b0;
    div_start    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (settle_q == 2'd0 && !s2_q) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (rise) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (fall) begin
          hi_d = cnt_q;
        end else if (rise) begin
          if (div_busy) begin
            overrun_d = 1'b1;
          end else begin
            div_start = 1'b1;
            res_per_d = cnt_q;
            res_hi_d  = hi_q;
          end
        end else if (cnt_q == CNT_MAX) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Results come from the snapshot taken at division start, not the live hi_q.
    if (div_done) begin
      period_cnt_d = res_per_q;
      high_cnt_d   = res_hi_q;
      duty_d       = div_quo[DUTY_W-1:0];
      valid_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      settle_q     <= 2'(SETTLE_CYCLES);
      cnt_q        <= '0;
      hi_q         <= '0;
      res_per_q    <= '0;
      res_hi_q     <= '0;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      duty_q       <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      settle_q     <= settle_d;
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      res_per_q    <= res_per_d;
      res_hi_q     <= res_hi_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      duty_q       <= duty_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  pwm_div #(
    .NUM_W(NUM_W),
    .DEN_W(CNT_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start      (div_start),
    .numerator  (div_num),
    .denominator(cnt_q),
    .busy       (div_busy),
    .done       (div_done),
    .quotient   (div_quo)
  );

  assign period_cnt = period_cnt_q;
  assign high_cnt   = high_cnt_q;
  assign duty_pct   = duty_q;
  assign valid      = valid_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule
